// File: rtl/dmem_lsu.sv
// Load/store unit in front of a byte-enabled data memory with a 1-cycle registered read.
// Checks legality and alignment, then drives the memory port and returns one response per request.
module dmem_lsu #(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      REQ_VALID,
    output logic                      REQ_READY,
    input  logic                      REQ_WE,
    input  logic [2:0]                REQ_FUNCT3,
    input  logic [31:0]               REQ_ADDR,
    input  logic [31:0]               REQ_WDATA,
    output logic                      RSP_VALID,
    input  logic                      RSP_READY,
    output logic [31:0]               RSP_RDATA,
    output logic                      RSP_ERR,
    output logic                      MEM_EN,
    output logic [3:0]                MEM_WE,
    output logic [MEM_ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [31:0]               MEM_WDATA,
    input  logic [31:0]               MEM_RDATA,
    output logic [1:0]                DBG_STATE
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
    // A response stays valid with stable data/err until RSP_READY is seen high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        is_half, is_word, illegal, misaligned, req_err, accept;
    logic [1:0]  req_off;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] load_data;

    assign req_off = REQ_ADDR[1:0];
    assign is_half = (REQ_FUNCT3[1:0] == 2'b01);
    assign is_word = (REQ_FUNCT3[1:0] == 2'b10);

    always_comb begin
        illegal = 1'b0;
        if (REQ_WE) begin
            illegal = (REQ_FUNCT3 > 3'd2);
        end else begin
            illegal = !(REQ_FUNCT3 == 3'b000 || REQ_FUNCT3 == 3'b001 ||
                        REQ_FUNCT3 == 3'b010 || REQ_FUNCT3 == 3'b100 ||
                        REQ_FUNCT3 == 3'b101);
        end
    end

    assign misaligned = (is_half && req_off[0]) || (is_word && (req_off != 2'b00));
    assign req_err    = illegal || misaligned;

    assign REQ_READY = RST_N && (state_q == IDLE);
    assign accept    = REQ_VALID && REQ_READY;

    assign MEM_ADDR = REQ_ADDR[MEM_ADDR_WIDTH+1:2];
    assign MEM_EN   = RST_N && (state_q == IDLE) && REQ_VALID && !req_err;

    // Stores replicate the datum across every lane so only the enables pick the target bytes.
    always_comb begin
        MEM_WE    = 4'b0000;
        MEM_WDATA = REQ_WDATA;
        if (REQ_WE) begin
            case (REQ_FUNCT3[1:0])
                2'b00:   MEM_WDATA = {4{REQ_WDATA[7:0]}};
                2'b01:   MEM_WDATA = {2{REQ_WDATA[15:0]}};
                default: MEM_WDATA = REQ_WDATA;
            endcase
            if (MEM_EN) begin
                case (REQ_FUNCT3[1:0])
                    2'b00:   MEM_WE = 4'b0001 << req_off;
                    2'b01:   MEM_WE = 4'b0011 << req_off;
                    default: MEM_WE = 4'b1111;
                endcase
            end
        end
    end

    assign lane8  = MEM_RDATA[{off_q, 3'b000} +: 8];
    assign lane16 = MEM_RDATA[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{lane8[7]}}, lane8};
            3'b001:  load_data = {{16{lane16[15]}}, lane16};
            3'b100:  load_data = {24'd0, lane8};
            3'b101:  load_data = {16'd0, lane16};
            default: load_data = MEM_RDATA;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d     = RESP;
                        rsp_rdata_d = 32'd0;
                        rsp_err_d   = 1'b1;
                    end else if (REQ_WE) begin
                        state_d     = RESP;
                        rsp_rdata_d = 32'd0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                state_d     = RESP;
                rsp_rdata_d = load_data;
                rsp_err_d   = 1'b0;
            end
            RESP: begin
                if (RSP_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                funct3_q <= REQ_FUNCT3;
                off_q    <= req_off;
            end
        end
    end

    assign RSP_VALID = (state_q == RESP);
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural byte-enabled memory (1-cycle registered read).
module tb_dmem_lsu;

    localparam int AW = 10;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WE;
    logic [2:0]    REQ_FUNCT3;
    logic [31:0]   REQ_ADDR;
    logic [31:0]   REQ_WDATA;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic [31:0]   RSP_RDATA;
    logic          RSP_ERR;
    logic          MEM_EN;
    logic [3:0]    MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [31:0]   MEM_WDATA;
    logic [31:0]   MEM_RDATA;
    logic [1:0]    DBG_STATE;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_lsu #(.MEM_ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .DBG_STATE(DBG_STATE)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    // Memory model: read-before-write, preloaded on the first edge
    logic [31:0] mem [0:1023];
    logic        mem_init = 1'b1;

    always @(posedge CLK) begin
        if (mem_init) begin
            mem[4]  <= 32'h8899AABB;
            mem[8]  <= 32'h11223344;
            mem[12] <= 32'hCAFEF00D;
            mem[17] <= 32'h00000000;
        end else if (MEM_EN) begin
            MEM_RDATA <= mem[MEM_ADDR];
            for (int b = 0; b < 4; b++) begin
                if (MEM_WE[b]) mem[MEM_ADDR][b*8 +: 8] <= MEM_WDATA[b*8 +: 8];
            end
        end
    end

    // Driver: one full request/response; checks memory port at T, latency, response
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_en, input logic [3:0] exp_we,
                           input logic [31:0] exp_wdata, input int exp_lat,
                           input logic [31:0] exp_rdata, input logic exp_err, input string name);
        int lat;
        @(posedge CLK); #1;
        REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr; REQ_WDATA = wdata;
        @(negedge CLK);
        n_checks++;
        if (REQ_READY !== 1'b1) begin n_fail++; $display("FAIL %s req_ready got %b want 1", name, REQ_READY); end
        n_checks++;
        if (MEM_EN !== exp_en) begin n_fail++; $display("FAIL %s mem_en got %b want %b", name, MEM_EN, exp_en); end
        n_checks++;
        if (MEM_WE !== exp_we) begin n_fail++; $display("FAIL %s mem_we got %b want %b", name, MEM_WE, exp_we); end
        n_checks++;
        if (MEM_ADDR !== addr[AW+1:2]) begin n_fail++; $display("FAIL %s mem_addr got %h want %h", name, MEM_ADDR, addr[AW+1:2]); end
        if (we && exp_en) begin
            n_checks++;
            if (MEM_WDATA !== exp_wdata) begin n_fail++; $display("FAIL %s mem_wdata got %h want %h", name, MEM_WDATA, exp_wdata); end
        end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        lat = 1;
        while (RSP_VALID !== 1'b1 && lat < 8) begin
            @(posedge CLK); #1;
            lat++;
        end
        n_checks++;
        if (RSP_VALID !== 1'b1) begin n_fail++; $display("FAIL %s rsp_timeout got rsp_valid %b want 1", name, RSP_VALID); end
        n_checks++;
        if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
        n_checks++;
        if (RSP_RDATA !== exp_rdata) begin n_fail++; $display("FAIL %s rsp_rdata got %h want %h", name, RSP_RDATA, exp_rdata); end
        n_checks++;
        if (RSP_ERR !== exp_err) begin n_fail++; $display("FAIL %s rsp_err got %b want %b", name, RSP_ERR, exp_err); end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        n_checks++;
        if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
            n_fail++; $display("FAIL %s post_handshake got valid %b ready %b want 0 1", name, RSP_VALID, REQ_READY);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_FUNCT3 = 3'b010;
        REQ_ADDR = 32'h10; REQ_WDATA = 32'h0; RSP_READY = 1'b0;
        @(posedge CLK); #1;
        mem_init = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (REQ_READY !== 1'b0 || MEM_EN !== 1'b0 || MEM_WE !== 4'b0000) begin
            n_fail++; $display("FAIL reset_gating got ready %b en %b we %b want 0 0 0", REQ_READY, MEM_EN, MEM_WE);
        end
        n_checks++;
        if (RSP_VALID !== 1'b0 || RSP_RDATA !== 32'd0 || RSP_ERR !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp got valid %b rdata %h err %b want 0 0 0", RSP_VALID, RSP_RDATA, RSP_ERR);
        end
        REQ_VALID = 1'b0;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if (DBG_STATE !== 2'd0 || REQ_READY !== 1'b1) begin
            n_fail++; $display("FAIL reset_release got state %0d ready %b want 0 1", DBG_STATE, REQ_READY);
        end
    endtask

    task automatic test_loads();
        run_req(1'b0, 3'b000, 32'h12, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'hFFFFFF99, 1'b0, "lb_0x12");
        run_req(1'b0, 3'b100, 32'h12, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'h00000099, 1'b0, "lbu_0x12");
        run_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'hFFFF8899, 1'b0, "lh_0x12");
        run_req(1'b0, 3'b101, 32'h10, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'h0000AABB, 1'b0, "lhu_0x10");
        run_req(1'b0, 3'b000, 32'h10, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'hFFFFFFBB, 1'b0, "lb_0x10");
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'h8899AABB, 1'b0, "lw_0x10");
    endtask

    task automatic test_stores();
        run_req(1'b1, 3'b001, 32'h22, 32'h0000BEEF, 1'b1, 4'b1100, 32'hBEEFBEEF, 1, 32'h0, 1'b0, "sh_0x22");
        run_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'hBEEF3344, 1'b0, "lw_after_sh");
        run_req(1'b1, 3'b000, 32'h21, 32'hFFFFFF5A, 1'b1, 4'b0010, 32'h5A5A5A5A, 1, 32'h0, 1'b0, "sb_0x21");
        run_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'hBEEF5A44, 1'b0, "lw_after_sb");
    endtask

    task automatic test_back_to_back();
        run_req(1'b1, 3'b010, 32'h40, 32'h12345678, 1'b1, 4'b1111, 32'h12345678, 1, 32'h0, 1'b0, "sw_0x40");
        run_req(1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'h12345678, 1'b0, "lw_0x40");
        run_req(1'b0, 3'b100, 32'h43, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'h00000012, 1'b0, "lbu_0x43");
        run_req(1'b0, 3'b001, 32'h42, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'h00001234, 1'b0, "lh_0x42");
    endtask

    task automatic test_errors();
        run_req(1'b0, 3'b010, 32'h31, 32'h0, 1'b0, 4'b0000, 32'h0, 1, 32'h0, 1'b1, "lw_misaligned");
        run_req(1'b1, 3'b001, 32'h33, 32'h0000FFFF, 1'b0, 4'b0000, 32'h0, 1, 32'h0, 1'b1, "sh_misaligned");
        run_req(1'b0, 3'b011, 32'h30, 32'h0, 1'b0, 4'b0000, 32'h0, 1, 32'h0, 1'b1, "load_f3_011");
        run_req(1'b1, 3'b100, 32'h30, 32'h11111111, 1'b0, 4'b0000, 32'h0, 1, 32'h0, 1'b1, "store_f3_100");
        run_req(1'b0, 3'b010, 32'h30, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'hCAFEF00D, 1'b0, "lw_unchanged");
    endtask

    task automatic test_backpressure();
        int waited;
        @(posedge CLK); #1;
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b001; REQ_ADDR = 32'h22; REQ_WDATA = 32'h0;
        @(posedge CLK); #1;
        waited = 0;
        while (RSP_VALID !== 1'b1 && waited < 8) begin
            @(posedge CLK); #1;
            waited++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_checks++;
            if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'hFFFFBEEF || RSP_ERR !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d] got valid %b rdata %h err %b want 1 ffffbeef 0", i, RSP_VALID, RSP_RDATA, RSP_ERR);
            end
            n_checks++;
            if (REQ_READY !== 1'b0 || MEM_EN !== 1'b0) begin
                n_fail++; $display("FAIL bp_busy[%0d] got ready %b en %b want 0 0", i, REQ_READY, MEM_EN);
            end
            @(posedge CLK); #1;
        end
        REQ_VALID = 1'b0;
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        n_checks++;
        if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got ready %b valid %b want 1 0", REQ_READY, RSP_VALID);
        end
    endtask

    task automatic test_reset_mid();
        // Reset while in LOAD
        @(posedge CLK); #1;
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h10;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        n_checks++;
        if (DBG_STATE !== 2'd1) begin n_fail++; $display("FAIL mid_load_state got %0d want 1", DBG_STATE); end
        #2 RST_N = 1'b0;
        #1;
        n_checks++;
        if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b0 || DBG_STATE !== 2'd0) begin
            n_fail++; $display("FAIL mid_load_async got valid %b ready %b state %0d want 0 0 0", RSP_VALID, REQ_READY, DBG_STATE);
        end
        @(negedge CLK); RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
                n_fail++; $display("FAIL mid_load_stale[%0d] got valid %b ready %b want 0 1", i, RSP_VALID, REQ_READY);
            end
        end
        // Reset while a store response is pending: the write stays committed
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h44; REQ_WDATA = 32'hA5A5A5A5;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        n_checks++;
        if (RSP_VALID !== 1'b1) begin n_fail++; $display("FAIL mid_store_rsp got %b want 1", RSP_VALID); end
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_store_async got %b want 0", RSP_VALID); end
        @(negedge CLK); RST_N = 1'b1;
        run_req(1'b0, 3'b010, 32'h44, 32'h0, 1'b1, 4'b0000, 32'h0, 2, 32'hA5A5A5A5, 1'b0, "lw_after_reset");
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit directly upstream of the core's data memory macro (byte write enables, 1-cycle registered read).
- Accepts one byte-addressed load/store request from the execute/memory stage.
- Checks funct3 legality and alignment, then generates the word address, byte write enables and lane-replicated store data for the memory.
- Extracts and sign/zero-extends load data and returns one response per request over a valid/ready handshake.

Parameters:
- MEM_ADDR_WIDTH, 10: width of the memory word-address port; the memory word address is REQ_ADDR[MEM_ADDR_WIDTH+1:2].

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST_N  input  1  asynchronous active-low reset
- REQ_VALID  input  1  request valid
- REQ_READY  output  1  unit can accept a request this cycle
- REQ_WE  input  1  1 = store, 0 = load
- REQ_FUNCT3  input  3  RV32I funct3 of the load/store
- REQ_ADDR  input  32  byte address
- REQ_WDATA  input  32  store data, right-aligned
- RSP_VALID  output  1  response valid
- RSP_READY  input  1  consumer accepts response
- RSP_RDATA  output  32  extended load data; 0 for stores and errors
- RSP_ERR  output  1  illegal funct3 or misaligned access
- MEM_EN  output  1  memory enable
- MEM_WE  output  4  memory byte write enables
- MEM_ADDR  output  MEM_ADDR_WIDTH  memory word address
- MEM_WDATA  output  32  memory write data
- MEM_RDATA  input  32  memory read data, valid one cycle after MEM_ADDR

Behaviour:
- Clock/reset: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset values: state=IDLE, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0. While RST_N=0, REQ_READY=0, MEM_EN=0 and MEM_WE=0 (combinational gating).
- FSM states: IDLE, LOAD, RESP.
- REQ_READY=1 only in IDLE. A request is accepted in cycle T when REQ_VALID & REQ_READY.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- Misalignment: half access with addr[0]=1; word access with addr[1:0]≠0. Byte accesses are never misaligned.
- Error = illegal | misaligned.
- Memory outputs (combinational):
  - MEM_ADDR = REQ_ADDR[MEM_ADDR_WIDTH+1:2] at all times.
  - MEM_EN = IDLE & REQ_VALID & ~error.
  - MEM_WE = 0 unless MEM_EN & REQ_WE.
  - SB: MEM_WE = 4'b0001 << addr[1:0]; MEM_WDATA = byte replicated ×4.
  - SH: MEM_WE = 4'b0011 << addr[1:0]; MEM_WDATA = halfword replicated ×2.
  - SW: MEM_WE = 4'b1111; MEM_WDATA = REQ_WDATA.
  - Loads: MEM_WE = 0; MEM_WDATA = REQ_WDATA (don't-care).
- At acceptance, capture funct3 and addr[1:0] into registers.
- Transitions out of IDLE on acceptance:
  - error → RESP with RSP_ERR=1, RSP_RDATA=0. No memory access. Response visible T+1.
  - legal store → RESP with RSP_ERR=0, RSP_RDATA=0. Write commits at the end of T; response visible T+1.
  - legal load → LOAD.
- LOAD (cycle T+1): MEM_RDATA holds the word. Select lane MEM_RDATA[off*8 +: 8] for byte loads, or [off*8 +: 16] for half loads. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word. Register the result into RSP_RDATA, set RSP_ERR=0, go to RESP. Response visible T+2.
- RESP: RSP_VALID=1. RSP_RDATA and RSP_ERR are held stable until RSP_READY=1; on that edge go to IDLE and drop RSP_VALID.
  - Next acceptance is no earlier than the cycle after the response handshake (no overlap).
  - Stores: max throughput 1 request per 2 cycles.
  - Loads: max throughput 1 request per 3 cycles.
- MEM_EN=0 and REQ_READY=0 in LOAD and RESP. REQ_VALID held high while busy is ignored.
- Reset asserted mid-operation (LOAD or RESP): response discarded, state → IDLE. A store accepted on an earlier edge stays committed in memory.
- Write-then-read: a load accepted after a store's response returns the new data, since the memory updates on the store's accept edge.

Test Plan:
- Reset, memory word 0x10 = 0x8899AABB; LB addr 0x12 → RSP_VALID at T+2, RSP_RDATA=0xFFFFFF99, RSP_ERR=0; LBU same addr → 0x00000099.
- SH addr 0x22, WDATA 0x0000BEEF → at T: MEM_WE=4'b1100, MEM_WDATA=0xBEEFBEEF, MEM_ADDR=8; RSP_VALID at T+1, RSP_RDATA=0; subsequent LW addr 0x20 → upper half 0xBEEF, lower half unchanged.
- LW addr 0x31 and SH addr 0x33 → MEM_EN=0, MEM_WE=0 at T; RSP_VALID at T+1, RSP_ERR=1, RSP_RDATA=0; memory unchanged.
- Illegal codes: load funct3=011, store funct3=100 → RSP_ERR=1, no memory access.
- Backpressure: RSP_READY=0 for 5 cycles after an LH response → RSP_VALID, RSP_RDATA, RSP_ERR stable; REQ_READY=0 throughout; REQ_READY=1 the cycle after RSP_READY rises.
- RST_N pulled low during LOAD → RSP_VALID=0, REQ_READY=0 immediately (asynchronous); after release, state=IDLE, REQ_READY=1, no stale response.
